// File: rtl/binary_to_gray_pkg.sv
// rtl/binary_to_gray_pkg.sv - shared Gray-code helpers
//
// Purpose: pure conversion functions shared by the binary-to-Gray block,
//          the companion Gray-to-binary block and the benches.
// Contents:
//   GRAY_MAX_WIDTH        widest supported code word
//   width_mask(width)     ones in the low 'width' bits
//   bin2gray(value,width) binary -> Gray over the low 'width' bits
//   gray2bin(value,width) Gray -> binary over the low 'width' bits
package binary_to_gray_pkg;

  localparam int GRAY_MAX_WIDTH = 32;

  function automatic logic [GRAY_MAX_WIDTH-1:0] width_mask(input int width);
    logic [GRAY_MAX_WIDTH-1:0] mask;
    if (width >= GRAY_MAX_WIDTH) begin
      mask = '1;
    end else begin
      mask = (32'd1 << width) - 32'd1;
    end
    return mask;
  endfunction

  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
    input logic [GRAY_MAX_WIDTH-1:0] value,
    input int                        width
  );
    logic [GRAY_MAX_WIDTH-1:0] v;
    v = value & width_mask(width);
    return v ^ (v >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it; the
  // doubling shifts build that prefix-XOR in log2(32) steps.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(
    input logic [GRAY_MAX_WIDTH-1:0] value,
    input int                        width
  );
    logic [GRAY_MAX_WIDTH-1:0] b;
    b = value & width_mask(width);
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    b = b ^ (b >> 8);
    b = b ^ (b >> 16);
    return b;
  endfunction

endpackage

// File: rtl/binary_to_gray.sv
// rtl/binary_to_gray.sv - registered binary-to-Gray converter
//
// Purpose: converts din to Gray code and registers it so dout is driven
//          straight from flip-flops and can be sampled in another clock
//          domain by a synchronizer.
// Parameters:
//   WIDTH  code width, 1..32
// Ports:
//   clock  in   rising-edge clock
//   aclr   in   asynchronous active-high clear, forces dout to 0
//   din    in   binary value, synchronous to clock
//   dout   out  Gray code of din, one cycle later
module binary_to_gray
  import binary_to_gray_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // This register feeds a CDC synchronizer: it must stay a single, unmerged,
  // unretimed bank so that only one bit can change per increment.
  (* keep = "true", dont_touch = "true", shreg_extract = "no", syn_preserve = 1 *)
  logic [WIDTH-1:0] gray_q;

  // Bitwise only: dout[i] = din[i+1] ^ din[i], MSB passes through.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      gray_q <= '0;
    end else begin
      gray_q <= din ^ (din >> 1);
    end
  end

  assign dout = gray_q;

endmodule

// File: tb/tb_binary_to_gray.sv
// tb/tb_binary_to_gray.sv - self-checking bench for binary_to_gray
module tb_binary_to_gray;
  import binary_to_gray_pkg::*;

  logic        clock = 1'b0;
  logic        aclr  = 1'b1;
  logic [9:0]  din10 = '0;
  logic [0:0]  din1  = '0;
  logic [1:0]  din2  = '0;
  logic [10:0] din11 = '0;
  logic [31:0] din32 = '0;
  logic [9:0]  dout10;
  logic [0:0]  dout1;
  logic [1:0]  dout2;
  logic [10:0] dout11;
  logic [31:0] dout32;

  int checks = 0;
  int errors = 0;

  binary_to_gray #(.WIDTH(10)) dut10 (.clock(clock), .aclr(aclr), .din(din10), .dout(dout10));
  binary_to_gray #(.WIDTH(1))  dut1  (.clock(clock), .aclr(aclr), .din(din1),  .dout(dout1));
  binary_to_gray #(.WIDTH(2))  dut2  (.clock(clock), .aclr(aclr), .din(din2),  .dout(dout2));
  binary_to_gray #(.WIDTH(11)) dut11 (.clock(clock), .aclr(aclr), .din(din11), .dout(dout11));
  binary_to_gray #(.WIDTH(32)) dut32 (.clock(clock), .aclr(aclr), .din(din32), .dout(dout32));

  always #5 clock = ~clock;

  typedef struct {
    int          width;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_din(input int w, input logic [31:0] v);
    case (w)
      1:       din1  = v[0:0];
      2:       din2  = v[1:0];
      11:      din11 = v[10:0];
      32:      din32 = v;
      default: din10 = v[9:0];
    endcase
  endtask

  function automatic logic [31:0] get_dout(input int w);
    case (w)
      1:       return {31'b0, dout1};
      2:       return {30'b0, dout2};
      11:      return {21'b0, dout11};
      32:      return dout32;
      default: return {22'b0, dout10};
    endcase
  endfunction

  initial begin
    vec_t vecs[$];
    int   widths[5] = '{10, 1, 2, 11, 32};
    logic [31:0] prev_din[5];
    logic [31:0] prev_gray;
    logic [31:0] r;

    vecs = '{
      '{10, 32'h0,        32'h0},
      '{10, 32'h5,        32'h7},
      '{10, 32'h3FF,      32'h200},
      '{10, 32'h2AA,      32'h3FF},
      '{10, 32'h200,      32'h300},
      '{1,  32'h0,        32'h0},
      '{1,  32'h1,        32'h1},
      '{1,  32'h0,        32'h0},
      '{2,  32'h1,        32'h1},
      '{2,  32'h2,        32'h3},
      '{2,  32'h3,        32'h2},
      '{11, 32'h5,        32'h7},
      '{11, 32'h7FF,      32'h400},
      '{11, 32'h2AA,      32'h3FF},
      '{32, 32'h5,        32'h7},
      '{32, 32'hFFFFFFFF, 32'h80000000},
      '{32, 32'hAAAAAAAA, 32'hFFFFFFFF},
      '{32, 32'h0,        32'h0}
    };

    // Reset state and release with din = 6.
    din10 = 10'd6;
    #2;
    check("reset_dout10", get_dout(10), 32'h0);
    check("reset_dout32", get_dout(32), 32'h0);
    step();
    check("reset_held_dout10", get_dout(10), 32'h0);
    #2;
    aclr = 1'b0;
    #1;
    check("release_before_edge", get_dout(10), 32'h0);
    step();
    check("release_first_edge", get_dout(10), 32'h5);

    // Directed vectors, one-cycle latency.
    foreach (vecs[k]) begin
      set_din(vecs[k].width, vecs[k].din);
      step();
      check($sformatf("vec%0d_w%0d", k, vecs[k].width), get_dout(vecs[k].width), vecs[k].exp);
    end

    // Output holds between edges even when din changes.
    din10 = 10'h005;
    step();
    din10 = 10'h3FF;
    #3;
    check("hold_mid_cycle", get_dout(10), 32'h7);
    step();
    check("hold_next_edge", get_dout(10), 32'h200);

    // Sweep 0..1023 then wrap to 0: one bit changes per step.
    din10 = 10'd0;
    step();
    prev_gray = get_dout(10);
    for (int i = 1; i <= 1024; i++) begin
      din10 = 10'(i % 1024);
      step();
      check($sformatf("sweep_onebit_%0d", i), 32'($countones(get_dout(10) ^ prev_gray)), 32'd1);
      check($sformatf("sweep_value_%0d", i), gray2bin(get_dout(10), 10), 32'(i % 1024));
      prev_gray = get_dout(10);
    end
    check("sweep_wrap_zero", get_dout(10), 32'h0);

    // Random round trip on every width.
    for (int j = 0; j < 5; j++) begin
      prev_din[j] = $urandom() & width_mask(widths[j]);
      set_din(widths[j], prev_din[j]);
    end
    for (int c = 0; c < 10000; c++) begin
      step();
      for (int j = 0; j < 5; j++) begin
        check($sformatf("round_trip_w%0d_c%0d", widths[j], c),
              gray2bin(get_dout(widths[j]), widths[j]), prev_din[j]);
        r = $urandom() & width_mask(widths[j]);
        prev_din[j] = r;
        set_din(widths[j], r);
      end
    end

    // Width 1 is a plain one-cycle delay.
    din1 = 1'b1;
    step();
    din1 = 1'b0;
    check("w1_delay_a", get_dout(1), 32'h1);
    step();
    check("w1_delay_b", get_dout(1), 32'h0);

    // Asynchronous clear mid-cycle with din = 3FF.
    din10 = 10'h3FF;
    step();
    check("pre_clear", get_dout(10), 32'h200);
    #2;
    aclr = 1'b1;
    #1;
    check("async_clear_before_edge", get_dout(10), 32'h0);
    check("async_clear_w32", get_dout(32), 32'h0);
    step();
    check("clear_held_1", get_dout(10), 32'h0);
    din10 = 10'h2AA;
    step();
    check("clear_held_2", get_dout(10), 32'h0);
    #2;
    aclr = 1'b0;
    step();
    check("after_clear_reload", get_dout(10), 32'h3FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
